// File: rtl/time_uart_reporter.sv
// rtl/time_uart_reporter.sv - once-per-second "HH:MM:SS\r\n" UART 8N1 time reporter
module time_uart_reporter #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tc_time_base,
   input  logic       enable,
   input  logic [4:0] q_hours,
   input  logic [5:0] q_minutes,
   input  logic [5:0] q_seconds,
   output logic       tx,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
   // The stop bit is split into STOP (CLKS_PER_BIT-1 cycles) and NEXT (1 cycle),
   // so advancing to the next char costs no extra line time.
   localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(CLKS_PER_BIT - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP,
      S_NEXT
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [3:0]       char_idx, char_idx_nxt;
   logic [7:0]       shift_reg, shift_reg_nxt;
   logic [7:0]       frame [10];
   logic [7:0]       frame_nxt [10];
   logic [4:0]       snap_hours, snap_hours_nxt;
   logic [5:0]       snap_minutes, snap_minutes_nxt;
   logic [5:0]       snap_seconds, snap_seconds_nxt;
   logic             tick_d, tick_d_nxt;
   logic             tx_nxt, busy_nxt, frame_done_nxt, overrun_nxt;
   logic [15:0]      h_chars, m_chars, s_chars;

   // Two ASCII digits {tens, units} of a binary field, or "??" when out of range.
   // Tens come from restoring subtraction of 40/20/10, giving the binary tens digit.
   function automatic logic [15:0] encode_field(input logic [5:0] v, input logic in_range);
      logic [5:0] rem;
      logic [2:0] tens;
      rem  = v;
      tens = 3'd0;
      if (rem >= 6'd40) begin
         rem     = rem - 6'd40;
         tens[2] = 1'b1;
      end
      if (rem >= 6'd20) begin
         rem     = rem - 6'd20;
         tens[1] = 1'b1;
      end
      if (rem >= 6'd10) begin
         rem     = rem - 6'd10;
         tens[0] = 1'b1;
      end
      if (in_range)
         return {8'h30 + {5'b00000, tens}, 8'h30 + {2'b00, rem}};
      else
         return 16'h3F3F;
   endfunction

   assign h_chars = encode_field({1'b0, snap_hours}, snap_hours <= 5'd23);
   assign m_chars = encode_field(snap_minutes, snap_minutes <= 6'd59);
   assign s_chars = encode_field(snap_seconds, snap_seconds <= 6'd59);

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         bit_cnt      <= '0;
         bit_idx      <= 3'd0;
         char_idx     <= 4'd0;
         shift_reg    <= 8'h00;
         frame        <= '{default: 8'h00};
         snap_hours   <= 5'd0;
         snap_minutes <= 6'd0;
         snap_seconds <= 6'd0;
         tick_d       <= 1'b0;
         tx           <= 1'b1;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_nxt;
         bit_cnt      <= bit_cnt_nxt;
         bit_idx      <= bit_idx_nxt;
         char_idx     <= char_idx_nxt;
         shift_reg    <= shift_reg_nxt;
         frame        <= frame_nxt;
         snap_hours   <= snap_hours_nxt;
         snap_minutes <= snap_minutes_nxt;
         snap_seconds <= snap_seconds_nxt;
         tick_d       <= tick_d_nxt;
         tx           <= tx_nxt;
         busy         <= busy_nxt;
         frame_done   <= frame_done_nxt;
         overrun      <= overrun_nxt;
      end
   end

   // Next-state and output decode for the frame sequencer.
   always_comb begin
      state_nxt        = state;
      bit_cnt_nxt      = bit_cnt;
      bit_idx_nxt      = bit_idx;
      char_idx_nxt     = char_idx;
      shift_reg_nxt    = shift_reg;
      frame_nxt        = frame;
      snap_hours_nxt   = snap_hours;
      snap_minutes_nxt = snap_minutes;
      snap_seconds_nxt = snap_seconds;
      tx_nxt           = tx;
      busy_nxt         = busy;
      frame_done_nxt   = 1'b0;
      // Delay the tick one cycle so the counters have already stepped when we sample.
      tick_d_nxt       = tc_time_base & enable;
      // A tick reaching us while busy (including the edge busy falls) is dropped.
      overrun_nxt      = tick_d & busy;

      case (state)
         S_IDLE: begin
            if (tick_d) begin
               snap_hours_nxt   = q_hours;
               snap_minutes_nxt = q_minutes;
               snap_seconds_nxt = q_seconds;
               busy_nxt         = 1'b1;
               state_nxt        = S_LOAD;
            end
         end
         S_LOAD: begin
            frame_nxt[0]  = h_chars[15:8];
            frame_nxt[1]  = h_chars[7:0];
            frame_nxt[2]  = 8'h3A;
            frame_nxt[3]  = m_chars[15:8];
            frame_nxt[4]  = m_chars[7:0];
            frame_nxt[5]  = 8'h3A;
            frame_nxt[6]  = s_chars[15:8];
            frame_nxt[7]  = s_chars[7:0];
            frame_nxt[8]  = 8'h0D;
            frame_nxt[9]  = 8'h0A;
            shift_reg_nxt = h_chars[15:8];
            char_idx_nxt  = 4'd0;
            tx_nxt        = 1'b0;
            bit_cnt_nxt   = BIT_RELOAD;
            state_nxt     = S_START;
         end
         S_START: begin
            if (bit_cnt == '0) begin
               tx_nxt      = shift_reg[0];
               bit_idx_nxt = 3'd0;
               bit_cnt_nxt = BIT_RELOAD;
               state_nxt   = S_DATA;
            end else begin
               bit_cnt_nxt = bit_cnt - 1'b1;
            end
         end
         S_DATA: begin
            if (bit_cnt == '0) begin
               if (bit_idx == 3'd7) begin
                  tx_nxt      = 1'b1;
                  bit_cnt_nxt = STOP_RELOAD;
                  state_nxt   = S_STOP;
               end else begin
                  shift_reg_nxt = {1'b0, shift_reg[7:1]};
                  tx_nxt        = shift_reg[1];
                  bit_idx_nxt   = bit_idx + 3'd1;
                  bit_cnt_nxt   = BIT_RELOAD;
               end
            end else begin
               bit_cnt_nxt = bit_cnt - 1'b1;
            end
         end
         S_STOP: begin
            if (bit_cnt == '0)
               state_nxt = S_NEXT;
            else
               bit_cnt_nxt = bit_cnt - 1'b1;
         end
         S_NEXT: begin
            if (char_idx == 4'd9) begin
               busy_nxt       = 1'b0;
               frame_done_nxt = 1'b1;
               state_nxt      = S_IDLE;
            end else begin
               char_idx_nxt  = char_idx + 4'd1;
               shift_reg_nxt = frame[char_idx + 4'd1];
               tx_nxt        = 1'b0;
               bit_cnt_nxt   = BIT_RELOAD;
               state_nxt     = S_START;
            end
         end
         default: begin
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_time_uart_reporter.sv
// tb/tb_time_uart_reporter.sv - scoreboard bench for time_uart_reporter
module tb_time_uart_reporter;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tc_time_base = 1'b0;
   logic       enable = 1'b0;
   logic [4:0] q_hours = 5'd0;
   logic [5:0] q_minutes = 6'd0;
   logic [5:0] q_seconds = 6'd0;
   logic       tx, busy, frame_done, overrun;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int fd_cnt = 0;
   int ovr_cnt = 0;
   int frames_expected = 0;
   logic [7:0] exp_q [$];

   time_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .reset        (reset),
      .tc_time_base (tc_time_base),
      .enable       (enable),
      .q_hours      (q_hours),
      .q_minutes    (q_minutes),
      .q_seconds    (q_seconds),
      .tx           (tx),
      .busy         (busy),
      .frame_done   (frame_done),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
      if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Reference model: two decimal digits per field, '?' pair when out of range.
   task automatic push_field(input int v, input int limit);
      if (v <= limit) begin
         exp_q.push_back(8'(8'h30 + v / 10));
         exp_q.push_back(8'(8'h30 + v % 10));
      end else begin
         exp_q.push_back(8'h3F);
         exp_q.push_back(8'h3F);
      end
   endtask

   task automatic push_frame(input int h, input int m, input int s);
      push_field(h, 23);
      exp_q.push_back(8'h3A);
      push_field(m, 59);
      exp_q.push_back(8'h3A);
      push_field(s, 59);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      frames_expected++;
   endtask

   // Call just after a negedge; the tick is sampled on the next posedge, when the counters step to h:m:s.
   task automatic do_tick(input int h, input int m, input int s, output int c0);
      tc_time_base = 1'b1;
      @(posedge clk);
      #1;
      tc_time_base = 1'b0;
      q_hours   = 5'(h);
      q_minutes = 6'(m);
      q_seconds = 6'(s);
      c0 = cyc;
   endtask

   task automatic wait_fd(output int c);
      c = -1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            c = cyc;
            break;
         end
      end
   endtask

   // UART receiver: every bit must hold CPB samples; bytes are popped from the scoreboard.
   initial begin : monitor
      logic [9:0] bits;
      logic [7:0] expb;
      bit ok;
      bit aborted;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && tx === 1'b0) begin
            ok = 1'b1;
            aborted = 1'b0;
            bits = '0;
            for (int b = 0; b < 10; b++) begin
               for (int k = 0; k < CPB; k++) begin
                  if (b != 0 || k != 0) @(negedge clk);
                  if (reset !== 1'b0) aborted = 1'b1;
                  if (k == 0) bits[b] = tx;
                  else if (tx !== bits[b]) ok = 1'b0;
               end
               if (aborted) break;
            end
            if (!aborted) begin
               check("bit_width_start_stop", 32'({ok, bits[0], bits[9]}), 32'b101);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got %02h, required no byte", bits[8:1]);
               end else begin
                  expb = exp_q.pop_front();
                  check("rx_byte", 32'(bits[8:1]), 32'(expb));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int c0, c1, c, ovr0, fd0, h, m, s, mid, exp_ovr;
      bit en;

      // Reset held three cycles, then idle.
      repeat (3) begin
         @(negedge clk);
         check("reset_state", 32'({tx, busy, frame_done, overrun}), 32'b1000);
      end
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("idle_state", 32'({tx, busy, frame_done, overrun}), 32'b1000);
      end

      // Basic frame with latency and length checks.
      enable = 1'b1;
      q_hours = 5'd12; q_minutes = 6'd34; q_seconds = 6'd56;
      @(negedge clk);
      do_tick(12, 34, 56, c0);
      push_frame(12, 34, 56);
      @(negedge clk);
      check("busy_at_T", 32'({busy, tx}), 32'b01);
      @(negedge clk);
      check("busy_at_T1", 32'({busy, tx}), 32'b11);
      @(negedge clk);
      check("start_bit_at_T2", 32'({busy, tx}), 32'b10);
      wait_fd(c);
      check("frame_done_cycle", 32'(c - c0), 32'd402);
      check("busy_low_with_done", 32'(busy), 32'd0);
      @(negedge clk);
      check("frame_done_one_cycle", 32'(frame_done), 32'd0);

      // Counters wrap on the tick edge; the post-increment time is reported.
      repeat (5) @(negedge clk);
      q_hours = 5'd23; q_minutes = 6'd59; q_seconds = 6'd59;
      @(negedge clk);
      do_tick(0, 0, 0, c0);
      push_frame(0, 0, 0);
      wait_fd(c);
      check("wrap_frame_done_cycle", 32'(c - c0), 32'd402);

      // Second tick mid-frame: overrun once, snapshot unchanged.
      repeat (3) @(negedge clk);
      q_hours = 5'd12; q_minutes = 6'd34; q_seconds = 6'd56;
      @(negedge clk);
      ovr0 = ovr_cnt;
      do_tick(12, 34, 56, c0);
      push_frame(12, 34, 56);
      repeat (50) @(negedge clk);
      do_tick(12, 34, 57, c1);
      wait_fd(c);
      check("overrun_frame_done_cycle", 32'(c - c0), 32'd402);
      check("overrun_count", 32'(ovr_cnt - ovr0), 32'd1);

      // Tick landing on the edge busy falls is dropped with overrun.
      repeat (3) @(negedge clk);
      do_tick(1, 2, 3, c0);
      push_frame(1, 2, 3);
      while (cyc < c0 + 400) @(negedge clk);
      ovr0 = ovr_cnt;
      do_tick(1, 2, 4, c1);
      wait_fd(c);
      check("edge_tick_frame_done_cycle", 32'(c - c0), 32'd402);
      repeat (20) @(negedge clk);
      check("edge_tick_no_new_frame", 32'({busy, tx}), 32'b01);
      check("edge_tick_overrun", 32'(ovr_cnt - ovr0), 32'd1);

      // Out-of-range fields become "??".
      do_tick(25, 7, 60, c0);
      push_frame(25, 7, 60);
      wait_fd(c);
      check("range_frame_done_cycle", 32'(c - c0), 32'd402);

      // Reset in the middle of char 3 data bits.
      repeat (3) @(negedge clk);
      do_tick(9, 8, 7, c0);
      push_frame(9, 8, 7);
      frames_expected--;
      repeat (100) @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      fd0 = fd_cnt;
      @(negedge clk);
      check("reset_midframe_tx_busy", 32'({tx, busy}), 32'b10);
      @(negedge clk);
      reset = 1'b0;
      repeat (500) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) break;
      end
      check("reset_midframe_quiet", 32'({tx, busy}), 32'b10);
      check("reset_midframe_no_done", 32'(fd_cnt - fd0), 32'd0);
      do_tick(9, 8, 7, c0);
      push_frame(9, 8, 7);
      wait_fd(c);
      check("after_reset_frame_done_cycle", 32'(c - c0), 32'd402);

      // enable=0: ticks ignored entirely.
      enable = 1'b0;
      ovr0 = ovr_cnt;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         do_tick(4, 5, 6, c0);
         repeat (10) begin
            @(negedge clk);
            check("disabled_idle", 32'({tx, busy}), 32'b10);
         end
      end
      check("disabled_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);

      // Randomized frames with mid-frame counter changes and stray ticks.
      for (int it = 0; it < 12; it++) begin
         h  = $urandom_range(0, 31);
         m  = $urandom_range(0, 63);
         s  = $urandom_range(0, 63);
         en = ($urandom_range(0, 3) != 0);
         enable = en;
         @(negedge clk);
         do_tick(h, m, s, c0);
         if (en) begin
            push_frame(h, m, s);
            ovr0 = ovr_cnt;
            mid = $urandom_range(3, 350);
            repeat (mid) @(negedge clk);
            enable = $urandom_range(0, 1);
            exp_ovr = enable ? 1 : 0;
            do_tick($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), c1);
            wait_fd(c);
            check("rand_frame_done_cycle", 32'(c - c0), 32'd402);
            check("rand_overrun", 32'(ovr_cnt - ovr0), 32'(exp_ovr));
         end else begin
            repeat (10) @(negedge clk);
            check("rand_disabled_idle", 32'({tx, busy}), 32'b10);
         end
      end

      repeat (20) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("frame_done_total", 32'(fd_cnt), 32'(frames_expected));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
